sargantana_icache_refill_ctrl: RTL and testbench
================================================

# sargantana_icache_refill_ctrl

Instruction-cache refill controller and consumer of the 8-bit replacement LFSR's way index. On a lookup miss it picks a victim way, the lowest-index invalid way or else the LFSR way. It then issues one line request to the memory side, waits for the response, and performs a single write into the data/tag arrays. It sits between the icache lookup pipeline, the replacement LFSR and the L2/memory request port.

## Interface
Parameters:
- ICACHE_N_WAY, 4: number of ways; power of two, at least 2.
- IDX_W, 6: set index width.
- TAG_W, 20: tag width.
- LINE_W, 512: cache line width in bits.
- TIMEOUT_CYC, 255: watchdog limit in cycles; used only with the timeout macro.

Ports (clock and reset first):
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- miss_valid_i, in, 1: lookup miss pending.
- miss_ready_o, out, 1: miss accepted when miss_valid_i and miss_ready_o are both high.
- miss_idx_i, in, IDX_W: set index of the missing line.
- miss_tag_i, in, TAG_W: tag of the missing line.
- way_valid_i, in, ICACHE_N_WAY: valid bits of the indexed set, sampled on miss acceptance.
- lfsr_way_i, in, $clog2(ICACHE_N_WAY): random way from the LFSR.
- lfsr_en_o, out, 1: advance the LFSR; one-cycle pulse.
- mem_req_valid_o, out, 1: line request valid.
- mem_req_ready_i, in, 1: line request accepted.
- mem_req_addr_o, out, TAG_W+IDX_W: line address {tag, idx}.
- mem_rsp_valid_i, in, 1: response valid; always accepted.
- mem_rsp_data_i, in, LINE_W: line data.
- mem_rsp_err_i, in, 1: response error.
- flush_i, in, 1: abort the refill in progress.
- wr_en_o, out, 1: array write strobe.
- wr_way_o, out, ICACHE_N_WAY: one-hot write way.
- wr_idx_o, out, IDX_W: write set index.
- wr_tag_o, out, TAG_W: write tag.
- wr_data_o, out, LINE_W: write data.
- busy_o, out, 1: asserted whenever the state is not IDLE.
- err_o, out, 1: one-cycle pulse on error response or timeout.

## Operation
The controller is a state machine with five states: IDLE, REQ, WAIT, DROP, WRITE.

- **IDLE**
  - miss_ready_o = !flush_i.
  - On acceptance, latch idx, tag and the victim, then go to REQ.
  - Victim rule: the lowest-index way with way_valid_i = 0. If all ways are valid, the victim is lfsr_way_i and lfsr_en_o is asserted in the same cycle.
  - lfsr_en_o is low at all other times.
- **REQ**
  - mem_req_valid_o = 1, and mem_req_addr_o stays stable until the handshake.
  - On handshake, go to WAIT, or to DROP if flush_i was seen during REQ or is high in the handshake cycle.
  - Once raised, a request is never withdrawn.
- **WAIT**
  - On mem_rsp_valid_i with err = 0, latch the data and go to WRITE.
  - On mem_rsp_valid_i with err = 1, pulse err_o and go to IDLE.
  - flush_i with no response in the same cycle: go to DROP.
  - flush_i together with a response: the response is consumed and no write follows; go to IDLE.
- **DROP**: wait for mem_rsp_valid_i, discard it (no err_o), then go to IDLE.
- **WRITE**
  - wr_en_o = !flush_i, for exactly one cycle; then go to IDLE.
  - wr_way_o is the one-hot of the latched victim.
  - wr_tag_o, wr_idx_o and wr_data_o carry the latched values.
- mem_rsp_valid_i in IDLE or REQ is a protocol violation and is ignored.
- Reset mid-operation returns to IDLE immediately and clears all latched state. Any outstanding response arriving later is ignored in IDLE.

Reset values:
- State is IDLE.
- All outputs are 0 except miss_ready_o, which is 1 in IDLE unless flush_i is high.

## Timing
- Miss accepted at cycle T: mem_req_valid_o is high from T+1.
- Request handshake at H: WAIT from H+1.
- Response at R: wr_en_o at R+1, IDLE and miss_ready_o at R+2.
- Minimum miss-to-write latency is 3 cycles (T+1 handshake, T+2 response, T+3 write).
- Exactly one refill is in flight; no miss is accepted while busy_o is high.
- lfsr_en_o pulses at most once per accepted miss, in the acceptance cycle.

## Configuration
- ICACHE_REFILL_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter resets on entry to WAIT or DROP and increments every cycle in those states.
  - When it reaches TIMEOUT_CYC with no response, pulse err_o (in WAIT only) and go to IDLE.
  - Late responses are then ignored.
- Not defined: no counter; WAIT and DROP wait indefinitely, and err_o comes only from mem_rsp_err_i.

## Test plan
- Set way_valid_i = 4'b1011 and miss idx 5, tag 0xABCDE. Required:
  - wr_way_o = 4'b0100 and lfsr_en_o never high.
  - mem_req_addr_o = {0xABCDE, 5}.
  - Write 3 cycles after acceptance when ready and response come immediately.
- Set way_valid_i = 4'b1111 and lfsr_way_i = 2. Required:
  - lfsr_en_o high for exactly the acceptance cycle.
  - wr_way_o = 4'b0100.
- Hold mem_req_ready_i low for 10 cycles. Required: mem_req_valid_o and the address stay stable, and miss_ready_o stays 0.
- Assert flush_i in REQ, then handshake, then a response 5 cycles later. Required: no wr_en_o, no err_o, IDLE the cycle after the response.
- Return a response with mem_rsp_err_i = 1. Required: err_o pulses 1 cycle, no write, miss_ready_o is 1 the next cycle.
- With ICACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYC = 16, send no response. Required:
  - err_o fires TIMEOUT_CYC cycles after entering WAIT.
  - A response injected later produces no write.

Source files
------------

// File: rtl/sargantana_icache_refill_ctrl.sv
// Icache refill controller: victim selection, one line request to memory, one array write.
// Optional watchdog on the response wait enabled by ICACHE_REFILL_TIMEOUT_EN.
module sargantana_icache_refill_ctrl #(
   parameter int unsigned ICACHE_N_WAY = 4,
   parameter int unsigned IDX_W        = 6,
   parameter int unsigned TAG_W        = 20,
   parameter int unsigned LINE_W       = 512,
   parameter int unsigned TIMEOUT_CYC  = 255
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            miss_valid_i,
   output logic                            miss_ready_o,
   input  logic [IDX_W-1:0]                miss_idx_i,
   input  logic [TAG_W-1:0]                miss_tag_i,
   input  logic [ICACHE_N_WAY-1:0]         way_valid_i,
   input  logic [$clog2(ICACHE_N_WAY)-1:0] lfsr_way_i,
   output logic                            lfsr_en_o,
   output logic                            mem_req_valid_o,
   input  logic                            mem_req_ready_i,
   output logic [TAG_W+IDX_W-1:0]          mem_req_addr_o,
   input  logic                            mem_rsp_valid_i,
   input  logic [LINE_W-1:0]               mem_rsp_data_i,
   input  logic                            mem_rsp_err_i,
   input  logic                            flush_i,
   output logic                            wr_en_o,
   output logic [ICACHE_N_WAY-1:0]         wr_way_o,
   output logic [IDX_W-1:0]                wr_idx_o,
   output logic [TAG_W-1:0]                wr_tag_o,
   output logic [LINE_W-1:0]               wr_data_o,
   output logic                            busy_o,
   output logic                            err_o
);

   localparam int unsigned WAY_W = $clog2(ICACHE_N_WAY);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DROP  = 3'd3,
      S_WRITE = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic [LINE_W-1:0]       data_q, data_d;
   logic [ICACHE_N_WAY-1:0] victim_oh_q, victim_oh_d;
   logic                    flush_seen_q, flush_seen_d;
   logic                    err_q, err_d;

   logic                    free_found;
   logic [WAY_W-1:0]        free_way;
   logic [WAY_W-1:0]        victim_way;
   logic                    miss_accept;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

   // Lowest-index invalid way; falls back to the LFSR way when the set is full
   always_comb begin
      free_found = 1'b0;
      free_way   = '0;
      for (int unsigned i = 0; i < ICACHE_N_WAY; i++) begin
         if (!way_valid_i[i] && !free_found) begin
            free_found = 1'b1;
            free_way   = WAY_W'(i);
         end
      end
      victim_way = free_found ? free_way : lfsr_way_i;
   end

   assign miss_accept     = (state_q == S_IDLE) && miss_valid_i && !flush_i;
   assign mem_req_addr_o  = {tag_q, idx_q};
   assign wr_way_o        = victim_oh_q;
   assign wr_idx_o        = idx_q;
   assign wr_tag_o        = tag_q;
   assign wr_data_o       = data_q;
   assign err_o           = err_q;

   // Next state, latched payload and state-decoded outputs
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      tag_d           = tag_q;
      data_d          = data_q;
      victim_oh_d     = victim_oh_q;
      flush_seen_d    = flush_seen_q;
      err_d           = 1'b0;
      miss_ready_o    = 1'b0;
      lfsr_en_o       = 1'b0;
      mem_req_valid_o = 1'b0;
      wr_en_o         = 1'b0;
      busy_o          = (state_q != S_IDLE);
`ifdef ICACHE_REFILL_TIMEOUT_EN
      cnt_d           = cnt_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            miss_ready_o = !flush_i;
            lfsr_en_o    = miss_accept && !free_found;
            if (miss_accept) begin
               idx_d        = miss_idx_i;
               tag_d        = miss_tag_i;
               victim_oh_d  = ICACHE_N_WAY'(1) << victim_way;
               flush_seen_d = 1'b0;
               state_d      = S_REQ;
            end
         end

         S_REQ: begin
            mem_req_valid_o = 1'b1;
            if (flush_i) flush_seen_d = 1'b1;
            if (mem_req_ready_i) begin
               state_d = (flush_seen_q || flush_i) ? S_DROP : S_WAIT;
`ifdef ICACHE_REFILL_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end

         S_WAIT: begin
`ifdef ICACHE_REFILL_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (mem_rsp_valid_i) begin
               // A flush coinciding with the response consumes it silently
               if (flush_i) begin
                  state_d = S_IDLE;
               end else if (mem_rsp_err_i) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  data_d  = mem_rsp_data_i;
                  state_d = S_WRITE;
               end
            end else if (flush_i) begin
               state_d = S_DROP;
`ifdef ICACHE_REFILL_TIMEOUT_EN
               cnt_d   = '0;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
`endif
            end
         end

         S_DROP: begin
`ifdef ICACHE_REFILL_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_rsp_valid_i || timeout) state_d = S_IDLE;
`else
            if (mem_rsp_valid_i) state_d = S_IDLE;
`endif
         end

         S_WRITE: begin
            wr_en_o = !flush_i;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         tag_q        <= '0;
         data_q       <= '0;
         victim_oh_q  <= '0;
         flush_seen_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         tag_q        <= tag_d;
         data_q       <= data_d;
         victim_oh_q  <= victim_oh_d;
         flush_seen_q <= flush_seen_d;
         err_q        <= err_d;
      end
   end

`ifdef ICACHE_REFILL_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`endif

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// Randomized bench for sargantana_icache_refill_ctrl against a transaction-level model,
// plus directed scenarios with literal expectations.
module tb_sargantana_icache_refill_ctrl;

   localparam int unsigned N_WAY  = 4;
   localparam int unsigned WAY_W  = 2;
   localparam int unsigned IDX_W  = 6;
   localparam int unsigned TAG_W  = 20;
   localparam int unsigned LINE_W = 512;
   localparam int unsigned TO_CYC = 16;

   logic                    clk = 1'b0;
   logic                    rst_ni;
   logic                    miss_valid_i;
   logic                    miss_ready_o;
   logic [IDX_W-1:0]        miss_idx_i;
   logic [TAG_W-1:0]        miss_tag_i;
   logic [N_WAY-1:0]        way_valid_i;
   logic [WAY_W-1:0]        lfsr_way_i;
   logic                    lfsr_en_o;
   logic                    mem_req_valid_o;
   logic                    mem_req_ready_i;
   logic [TAG_W+IDX_W-1:0]  mem_req_addr_o;
   logic                    mem_rsp_valid_i;
   logic [LINE_W-1:0]       mem_rsp_data_i;
   logic                    mem_rsp_err_i;
   logic                    flush_i;
   logic                    wr_en_o;
   logic [N_WAY-1:0]        wr_way_o;
   logic [IDX_W-1:0]        wr_idx_o;
   logic [TAG_W-1:0]        wr_tag_o;
   logic [LINE_W-1:0]       wr_data_o;
   logic                    busy_o;
   logic                    err_o;

   always #5 clk = ~clk;

   sargantana_icache_refill_ctrl #(
      .ICACHE_N_WAY(N_WAY), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
      .miss_idx_i(miss_idx_i), .miss_tag_i(miss_tag_i),
      .way_valid_i(way_valid_i), .lfsr_way_i(lfsr_way_i), .lfsr_en_o(lfsr_en_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
      .mem_rsp_err_i(mem_rsp_err_i), .flush_i(flush_i),
      .wr_en_o(wr_en_o), .wr_way_o(wr_way_o), .wr_idx_o(wr_idx_o),
      .wr_tag_o(wr_tag_o), .wr_data_o(wr_data_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   int checks   = 0;
   int failures = 0;

   // Transaction-level model of the one refill in flight
   bit                m_busy, m_req_out, m_doomed, m_write_due, m_err;
   logic [IDX_W-1:0]  m_idx;
   logic [TAG_W-1:0]  m_tag;
   logic [LINE_W-1:0] m_data;
   int                m_way;
   int                m_wcnt;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_line(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < int'(LINE_W / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int first_free(input logic [N_WAY-1:0] v);
      for (int i = 0; i < int'(N_WAY); i++) if (!v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_req_out = 0; m_doomed = 0; m_write_due = 0; m_err = 0;
      m_idx = '0; m_tag = '0; m_data = '0; m_way = 0; m_wcnt = 0;
   endtask

   task automatic model_check();
      logic [TAG_W+IDX_W-1:0] e_addr;
      e_addr = {m_tag, m_idx};
      chk("busy", 64'(busy_o), 64'(m_busy));
      chk("miss_ready", 64'(miss_ready_o), 64'(!m_busy && !flush_i));
      chk("lfsr_en", 64'(lfsr_en_o), 64'(!m_busy && miss_valid_i && !flush_i && (&way_valid_i)));
      chk("req_valid", 64'(mem_req_valid_o), 64'(m_busy && m_req_out));
      chk("wr_en", 64'(wr_en_o), 64'(m_write_due && !flush_i));
      chk("err", 64'(err_o), 64'(m_err));
      if (m_busy && m_req_out) chk("req_addr", 64'(mem_req_addr_o), 64'(e_addr));
      if (m_write_due) begin
         chk("wr_way", 64'(wr_way_o), 64'(N_WAY'(1) << m_way));
         chk("wr_idx", 64'(wr_idx_o), 64'(m_idx));
         chk("wr_tag", 64'(wr_tag_o), 64'(m_tag));
         chk_line("wr_data", wr_data_o, m_data);
      end
   endtask

   // Advance the model by one clock using the inputs held during that cycle
   task automatic model_update();
      int ff;
      m_err = 0;
      if (!m_busy) begin
         if (miss_valid_i && !flush_i) begin
            ff        = first_free(way_valid_i);
            m_way     = (ff >= 0) ? ff : int'(lfsr_way_i);
            m_idx     = miss_idx_i;
            m_tag     = miss_tag_i;
            m_busy    = 1;
            m_req_out = 1;
            m_doomed  = 0;
         end
      end else if (m_req_out) begin
         if (flush_i) m_doomed = 1;
         if (mem_req_ready_i) begin
            m_req_out = 0;
            m_wcnt    = 0;
         end
      end else if (m_write_due) begin
         m_write_due = 0;
         m_busy      = 0;
      end else if (mem_rsp_valid_i) begin
         if (m_doomed || flush_i) begin
            m_busy = 0;
         end else if (mem_rsp_err_i) begin
            m_busy = 0;
            m_err  = 1;
         end else begin
            m_data      = mem_rsp_data_i;
            m_write_due = 1;
         end
      end else if (flush_i && !m_doomed) begin
         m_doomed = 1;
         m_wcnt   = 0;
      end
`ifdef ICACHE_REFILL_TIMEOUT_EN
      else if (m_wcnt == int'(TO_CYC) - 1) begin
         m_busy = 0;
         m_err  = !m_doomed;
      end else begin
         m_wcnt++;
      end
`endif
   endtask

   task automatic cyc_check();
      #1;
      model_check();
   endtask

   task automatic cyc_adv();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_in();
      miss_valid_i    = 0;
      flush_i         = 0;
      mem_req_ready_i = 0;
      mem_rsp_valid_i = 0;
      mem_rsp_err_i   = 0;
      way_valid_i     = '0;
      lfsr_way_i      = '0;
   endtask

   task automatic accept_miss(input logic [N_WAY-1:0] vv, input logic [WAY_W-1:0] lw);
      miss_valid_i = 1;
      miss_idx_i   = IDX_W'($urandom);
      miss_tag_i   = TAG_W'($urandom);
      way_valid_i  = vv;
      lfsr_way_i   = lw;
      cyc_check();
      cyc_adv();
      miss_valid_i = 0;
   endtask

   task automatic rand_inputs();
      miss_valid_i    = 1'($urandom_range(0, 1));
      flush_i         = ($urandom_range(0, 15) == 0);
      mem_req_ready_i = 1'($urandom_range(0, 1));
      mem_rsp_valid_i = ($urandom_range(0, 9) < 3);
      mem_rsp_err_i   = !flush_i && ($urandom_range(0, 7) == 0);
      way_valid_i     = ($urandom_range(0, 2) == 0) ? '1 : N_WAY'($urandom);
      lfsr_way_i      = WAY_W'($urandom);
      miss_idx_i      = IDX_W'($urandom);
      miss_tag_i      = TAG_W'($urandom);
      mem_rsp_data_i  = rand_line();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LINE_W-1:0]      d;
      logic [TAG_W+IDX_W-1:0] exp_addr;

      rst_ni = 0;
      idle_in();
      miss_idx_i     = '0;
      miss_tag_i     = '0;
      mem_rsp_data_i = '0;
      model_reset();

      // Reset values
      #1;
      chk("rst_miss_ready", 64'(miss_ready_o), 64'(1));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_req_valid", 64'(mem_req_valid_o), 64'(0));
      chk("rst_req_addr", 64'(mem_req_addr_o), 64'(0));
      chk("rst_wr_en", 64'(wr_en_o), 64'(0));
      chk("rst_wr_way", 64'(wr_way_o), 64'(0));
      chk("rst_err", 64'(err_o), 64'(0));
      chk("rst_lfsr_en", 64'(lfsr_en_o), 64'(0));
      repeat (2) @(negedge clk);
      rst_ni = 1;

      // Free way 2 chosen from 4'b1011, back-to-back handshake and response
      miss_valid_i = 1;
      miss_idx_i   = 6'd5;
      miss_tag_i   = 20'hABCDE;
      way_valid_i  = 4'b1011;
      lfsr_way_i   = 2'd3;
      cyc_check();
      chk("t1_lfsr_en_acc", 64'(lfsr_en_o), 64'(0));
      chk("t1_miss_ready", 64'(miss_ready_o), 64'(1));
      cyc_adv();
      miss_valid_i    = 0;
      mem_req_ready_i = 1;
      cyc_check();
      exp_addr = {20'hABCDE, 6'd5};
      chk("t1_req_valid", 64'(mem_req_valid_o), 64'(1));
      chk("t1_req_addr", 64'(mem_req_addr_o), 64'(exp_addr));
      cyc_adv();
      mem_req_ready_i = 0;
      mem_rsp_valid_i = 1;
      d               = rand_line();
      mem_rsp_data_i  = d;
      cyc_check();
      chk("t1_lfsr_en_rsp", 64'(lfsr_en_o), 64'(0));
      cyc_adv();
      mem_rsp_valid_i = 0;
      cyc_check();
      chk("t1_wr_en", 64'(wr_en_o), 64'(1));
      chk("t1_wr_way", 64'(wr_way_o), 64'(4'b0100));
      chk("t1_wr_idx", 64'(wr_idx_o), 64'(5));
      chk("t1_wr_tag", 64'(wr_tag_o), 64'(20'hABCDE));
      chk_line("t1_wr_data", wr_data_o, d);
      cyc_adv();
      cyc_check();
      chk("t1_idle_ready", 64'(miss_ready_o), 64'(1));
      chk("t1_idle_busy", 64'(busy_o), 64'(0));
      cyc_adv();

      // Full set: LFSR way 2, single lfsr_en pulse
      miss_valid_i = 1;
      way_valid_i  = 4'b1111;
      lfsr_way_i   = 2'd2;
      cyc_check();
      chk("t2_lfsr_en_acc", 64'(lfsr_en_o), 64'(1));
      cyc_adv();
      miss_valid_i    = 0;
      mem_req_ready_i = 1;
      cyc_check();
      chk("t2_lfsr_en_after", 64'(lfsr_en_o), 64'(0));
      cyc_adv();
      mem_req_ready_i = 0;
      mem_rsp_valid_i = 1;
      mem_rsp_data_i  = rand_line();
      cyc_check();
      cyc_adv();
      mem_rsp_valid_i = 0;
      cyc_check();
      chk("t2_wr_en", 64'(wr_en_o), 64'(1));
      chk("t2_wr_way", 64'(wr_way_o), 64'(4'b0100));
      cyc_adv();

      // Backpressure on the request for 10 cycles
      accept_miss(4'b0000, 2'd0);
      exp_addr = {m_tag, m_idx};
      miss_valid_i = 1;
      for (int i = 0; i < 10; i++) begin
         cyc_check();
         chk("t3_req_valid_hold", 64'(mem_req_valid_o), 64'(1));
         chk("t3_req_addr_hold", 64'(mem_req_addr_o), 64'(exp_addr));
         chk("t3_miss_ready_low", 64'(miss_ready_o), 64'(0));
         cyc_adv();
      end
      miss_valid_i    = 0;
      mem_req_ready_i = 1;
      cyc_check();
      cyc_adv();
      mem_req_ready_i = 0;
      mem_rsp_valid_i = 1;
      mem_rsp_data_i  = rand_line();
      cyc_check();
      cyc_adv();
      mem_rsp_valid_i = 0;
      cyc_check();
      chk("t3_wr_way", 64'(wr_way_o), 64'(4'b0001));
      cyc_adv();

      // Flush during REQ: handshake, response 5 cycles later is dropped
      accept_miss(4'b0110, 2'd1);
      flush_i = 1;
      cyc_check();
      cyc_adv();
      flush_i         = 0;
      mem_req_ready_i = 1;
      cyc_check();
      cyc_adv();
      mem_req_ready_i = 0;
      for (int i = 0; i < 4; i++) begin
         cyc_check();
         chk("t4_drop_busy", 64'(busy_o), 64'(1));
         cyc_adv();
      end
      mem_rsp_valid_i = 1;
      mem_rsp_data_i  = rand_line();
      cyc_check();
      cyc_adv();
      mem_rsp_valid_i = 0;
      cyc_check();
      chk("t4_no_wr", 64'(wr_en_o), 64'(0));
      chk("t4_no_err", 64'(err_o), 64'(0));
      chk("t4_idle", 64'(busy_o), 64'(0));
      cyc_adv();

      // Error response
      accept_miss(4'b1110, 2'd3);
      mem_req_ready_i = 1;
      cyc_check();
      cyc_adv();
      mem_req_ready_i = 0;
      mem_rsp_valid_i = 1;
      mem_rsp_err_i   = 1;
      cyc_check();
      cyc_adv();
      mem_rsp_valid_i = 0;
      mem_rsp_err_i   = 0;
      cyc_check();
      chk("t5_err", 64'(err_o), 64'(1));
      chk("t5_no_wr", 64'(wr_en_o), 64'(0));
      chk("t5_miss_ready", 64'(miss_ready_o), 64'(1));
      cyc_adv();
      cyc_check();
      chk("t5_err_pulse_end", 64'(err_o), 64'(0));
      cyc_adv();

`ifdef ICACHE_REFILL_TIMEOUT_EN
      // Watchdog: no response, err_o TO_CYC cycles after entering WAIT
      accept_miss(4'b0011, 2'd0);
      mem_req_ready_i = 1;
      cyc_check();
      cyc_adv();
      mem_req_ready_i = 0;
      for (int i = 0; i < int'(TO_CYC); i++) begin
         cyc_check();
         chk("t6_no_err_early", 64'(err_o), 64'(0));
         cyc_adv();
      end
      cyc_check();
      chk("t6_timeout_err", 64'(err_o), 64'(1));
      chk("t6_timeout_idle", 64'(busy_o), 64'(0));
      cyc_adv();
      mem_rsp_valid_i = 1;
      mem_rsp_data_i  = rand_line();
      cyc_check();
      cyc_adv();
      mem_rsp_valid_i = 0;
      cyc_check();
      chk("t6_late_no_wr", 64'(wr_en_o), 64'(0));
      cyc_adv();
`endif

      // Asynchronous reset mid-refill, later stray response ignored
      accept_miss(4'b0000, 2'd0);
      cyc_check();
      #2 rst_ni = 0;
      #1;
      chk("t7_rst_busy", 64'(busy_o), 64'(0));
      chk("t7_rst_req_valid", 64'(mem_req_valid_o), 64'(0));
      chk("t7_rst_miss_ready", 64'(miss_ready_o), 64'(1));
      model_reset();
      @(negedge clk);
      rst_ni          = 1;
      mem_rsp_valid_i = 1;
      mem_rsp_data_i  = rand_line();
      cyc_check();
      cyc_adv();
      mem_rsp_valid_i = 0;
      cyc_check();
      chk("t7_stray_no_wr", 64'(wr_en_o), 64'(0));
      chk("t7_stray_idle", 64'(busy_o), 64'(0));
      cyc_adv();

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rand_inputs();
         cyc_check();
         cyc_adv();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
